// File: rtl/lc3b_types.sv
// Shared LC-3b core types: CDB broadcast format, ROB addressing and arbiter request bundle.
package lc3b_types;

    typedef logic [15:0] lc3b_word;
    typedef logic [2:0]  lc3b_rob_addr;

    typedef struct packed {
        logic         valid;
        lc3b_word     data;
        lc3b_rob_addr tag;
    } cdb_t;

    localparam int CDB_N_REQ = 4;

    typedef struct packed {
        logic         valid;
        lc3b_word     data;
        lc3b_rob_addr tag;
    } cdb_req_t;

endpackage

// File: rtl/cdb_rr_pick.sv
// Rotating-priority picker: first set request at or above rr_ptr, wrapping modulo N_REQ.
module cdb_rr_pick #(
    parameter int N_REQ = 4,
    parameter int PW    = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic [N_REQ-1:0] req,
    input  logic [PW-1:0]    rr_ptr,
    output logic [N_REQ-1:0] grant,
    output logic [PW-1:0]    idx
);

    logic [PW-1:0] pos;
    logic          found;

    always_comb begin
        grant = '0;
        idx   = '0;
        found = 1'b0;
        pos   = rr_ptr;
        for (int k = 0; k < N_REQ; k++) begin
            if (!found && req[pos]) begin
                grant[pos] = 1'b1;
                idx        = pos;
                found      = 1'b1;
            end
            // explicit wrap so non-power-of-2 N_REQ never visits an unused index
            pos = (pos == PW'(N_REQ - 1)) ? '0 : PW'(pos + PW'(1));
        end
    end

endmodule

// File: rtl/cdb_arbiter.sv
// CDB arbiter: ROB-head bypass first, round-robin otherwise; winner registered onto the CDB.
module cdb_arbiter
    import lc3b_types::*;
#(
    parameter int N_REQ = CDB_N_REQ
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [N_REQ-1:0]         req_valid,
    input  lc3b_word [N_REQ-1:0]     req_data,
    input  lc3b_rob_addr [N_REQ-1:0] req_tag,
    output logic [N_REQ-1:0]         req_ready,
    input  lc3b_rob_addr             rob_head,
    input  logic                     flush,
    output cdb_t                     cdb_out,
    output logic [2:0]               grant_idx
);

    localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    logic [PW-1:0]    rr_ptr;
    logic [N_REQ-1:0] head_hit;
    logic [N_REQ-1:0] hit_oh;
    logic [PW-1:0]    hit_idx;
    logic             hit_any;
    logic [N_REQ-1:0] rr_oh;
    logic [PW-1:0]    rr_idx;
    logic [PW-1:0]    g_idx;
    logic             gnt_any;

    for (genvar i = 0; i < N_REQ; i++) begin : g_hit
        assign head_hit[i] = req_valid[i] && (req_tag[i] == rob_head);
    end

    // lowest matching index wins; more than one match only happens with a stale tag
    always_comb begin
        hit_oh  = '0;
        hit_idx = '0;
        hit_any = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            if (head_hit[i] && !hit_any) begin
                hit_oh[i] = 1'b1;
                hit_idx   = PW'(i);
                hit_any   = 1'b1;
            end
        end
    end

    cdb_rr_pick #(.N_REQ(N_REQ), .PW(PW)) u_pick (
        .req    (req_valid),
        .rr_ptr (rr_ptr),
        .grant  (rr_oh),
        .idx    (rr_idx)
    );

    always_comb begin
        req_ready = '0;
        g_idx     = '0;
        if (!flush) begin
            if (hit_any) begin
                req_ready = hit_oh;
                g_idx     = hit_idx;
            end else begin
                req_ready = rr_oh;
                g_idx     = rr_idx;
            end
        end
    end

    assign gnt_any = |req_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cdb_out   <= '0;
            grant_idx <= '0;
            rr_ptr    <= '0;
        end else if (gnt_any) begin
            cdb_out.valid <= 1'b1;
            cdb_out.data  <= req_data[g_idx];
            cdb_out.tag   <= req_tag[g_idx];
            grant_idx     <= 3'(g_idx);
            rr_ptr        <= (g_idx == PW'(N_REQ - 1)) ? '0 : PW'(g_idx + PW'(1));
        end else begin
            cdb_out.valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter: reset, round-robin, head bypass, flush, idle/wrap, N_REQ=3.
module tb_cdb_arbiter;
    import lc3b_types::*;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic [3:0]         req_valid;
    lc3b_word [3:0]     req_data;
    lc3b_rob_addr [3:0] req_tag;
    logic [3:0]         req_ready;
    lc3b_rob_addr       rob_head;
    logic               flush;
    cdb_t               cdb_out;
    logic [2:0]         grant_idx;

    logic [2:0]         v3;
    lc3b_word [2:0]     d3;
    lc3b_rob_addr [2:0] t3;
    logic [2:0]         rdy3;
    lc3b_rob_addr       head3;
    logic               flush3;
    cdb_t               cdb3;
    logic [2:0]         idx3;

    int checks = 0;
    int errors = 0;

    cdb_arbiter #(.N_REQ(4)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data),
        .req_tag(req_tag), .req_ready(req_ready), .rob_head(rob_head),
        .flush(flush), .cdb_out(cdb_out), .grant_idx(grant_idx)
    );

    cdb_arbiter #(.N_REQ(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .req_valid(v3), .req_data(d3),
        .req_tag(t3), .req_ready(rdy3), .rob_head(head3),
        .flush(flush3), .cdb_out(cdb3), .grant_idx(idx3)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic edge_settle();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [19:0] bc(input logic v, input lc3b_word d, input lc3b_rob_addr t);
        return {v, d, t};
    endfunction

    initial begin
        rst_n = 1'b0; flush = 1'b0; rob_head = 3'd7;
        req_valid = '0; req_data = '0; req_tag = '0;
        v3 = '0; d3 = '0; t3 = '0; head3 = 3'd7; flush3 = 1'b0;
        #2;
        chk("rst_cdb", 32'(cdb_out), 32'h0);
        chk("rst_idx", 32'(grant_idx), 32'h0);
        chk("rst_ready", 32'(req_ready), 32'h0);
        @(negedge clk); rst_n = 1'b1;
        edge_settle();

        // single requester 2 so the CDB is mid-broadcast when reset hits
        req_valid = 4'b0100; req_data[2] = 16'h2222; req_tag[2] = 3'd2;
        @(negedge clk); chk("r2_ready", 32'(req_ready), 32'h4);
        edge_settle();
        chk("r2_cdb", 32'(cdb_out), 32'(bc(1'b1, 16'h2222, 3'd2)));
        chk("r2_idx", 32'(grant_idx), 32'd2);
        req_valid = '0;

        rst_n = 1'b0; #1;
        chk("async_rst_cdb", 32'(cdb_out), 32'h0);
        chk("async_rst_idx", 32'(grant_idx), 32'h0);
        req_valid = 4'b0010; req_data[1] = 16'h1111; req_tag[1] = 3'd1;
        @(negedge clk); rst_n = 1'b1; #1;
        chk("post_rst_ready", 32'(req_ready), 32'h2);
        edge_settle();
        chk("post_rst_cdb", 32'(cdb_out), 32'(bc(1'b1, 16'h1111, 3'd1)));
        chk("post_rst_idx", 32'(grant_idx), 32'd1);

        // idle and wrap: requester 3 alone, then an idle cycle holding data
        req_valid = 4'b1000; req_data[3] = 16'h3333; req_tag[3] = 3'd3;
        @(negedge clk); chk("w3_ready", 32'(req_ready), 32'h8);
        edge_settle();
        chk("w3_cdb", 32'(cdb_out), 32'(bc(1'b1, 16'h3333, 3'd3)));
        req_valid = '0;
        @(negedge clk); chk("idle_ready", 32'(req_ready), 32'h0);
        edge_settle();
        chk("idle_cdb", 32'(cdb_out), 32'(bc(1'b0, 16'h3333, 3'd3)));
        chk("idle_idx", 32'(grant_idx), 32'd3);

        // all valid, none at head: rr_ptr wrapped to 0 so order is 0,1,2,3,0,...
        req_valid = 4'b1111;
        for (int i = 0; i < 4; i++) begin
            req_data[i] = 16'h1000 + 16'(i);
            req_tag[i]  = 3'(i);
        end
        rob_head = 3'd7;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk); chk($sformatf("rr_ready%0d", k), 32'(req_ready), 32'(1 << (k % 4)));
            edge_settle();
            chk($sformatf("rr_cdb%0d", k), 32'(cdb_out),
                32'(bc(1'b1, 16'h1000 + 16'(k % 4), 3'(k % 4))));
            chk($sformatf("rr_idx%0d", k), 32'(grant_idx), 32'(k % 4));
        end

        // head bypass from rr_ptr=0: requester 2 carries the head tag
        req_valid = 4'b1101; req_tag[2] = 3'd5; req_data[2] = 16'hBEEF; rob_head = 3'd5;
        @(negedge clk); chk("hb_ready", 32'(req_ready), 32'h4);
        edge_settle();
        chk("hb_cdb", 32'(cdb_out), 32'(bc(1'b1, 16'hBEEF, 3'd5)));
        chk("hb_idx", 32'(grant_idx), 32'd2);
        rob_head = 3'd7;
        @(negedge clk); chk("hb_rr3_ready", 32'(req_ready), 32'h8);
        edge_settle();
        chk("hb_rr3_idx", 32'(grant_idx), 32'd3);

        // flush blocks the grant and leaves rr_ptr at 0
        req_valid = 4'b0011; flush = 1'b1;
        @(negedge clk); chk("fl_ready", 32'(req_ready), 32'h0);
        edge_settle();
        chk("fl_cdb", 32'(cdb_out), 32'(bc(1'b0, 16'h1003, 3'd3)));
        chk("fl_idx", 32'(grant_idx), 32'd3);
        flush = 1'b0;
        @(negedge clk); chk("postfl_ready", 32'(req_ready), 32'h1);
        edge_settle();
        chk("postfl_cdb", 32'(cdb_out), 32'(bc(1'b1, 16'h1000, 3'd0)));

        // flush overrides a head match too
        req_valid = 4'b0100; rob_head = 3'd5; flush = 1'b1;
        @(negedge clk); chk("fl_hb_ready", 32'(req_ready), 32'h0);
        flush = 1'b0;
        // two stale matches: lowest index wins regardless of rr_ptr
        req_valid = 4'b1100; req_tag[2] = 3'd6; req_tag[3] = 3'd6; rob_head = 3'd6;
        #1; chk("multi_hit_ready", 32'(req_ready), 32'h4);
        edge_settle();
        chk("multi_hit_idx", 32'(grant_idx), 32'd2);
        req_valid = '0;

        // N_REQ=3: grants cycle 0,1,2,0,1 without touching index 3
        v3 = 3'b111; head3 = 3'd7;
        for (int i = 0; i < 3; i++) begin
            d3[i] = 16'hA000 + 16'(i);
            t3[i] = 3'(i);
        end
        for (int k = 0; k < 5; k++) begin
            @(negedge clk); chk($sformatf("n3_ready%0d", k), 32'(rdy3), 32'(1 << (k % 3)));
            edge_settle();
            chk($sformatf("n3_cdb%0d", k), 32'(cdb3), 32'(bc(1'b1, 16'hA000 + 16'(k % 3), 3'(k % 3))));
            chk($sformatf("n3_idx%0d", k), 32'(idx3), 32'(k % 3));
        end
        v3 = '0;
        edge_settle();
        chk("n3_idle_valid", 32'(cdb3.valid), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/cdb_arbiter.md
# cdb_arbiter

Arbitrates the single common data bus (CDB) among the out-of-order core's result producers: ALU reservation stations, load buffer, and branch unit. Each cycle it grants at most one requester, with priority to the result the ROB head is waiting on and round-robin fairness otherwise. It registers the winner onto the CDB broadcast read by the reservation stations, ROB and register file.

## Interface
- N_REQ, 4, number of requesters (2..8)
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- req_valid  in  N_REQ  requester i holds a result
- req_data  in  N_REQ x 16  result word (lc3b_word) per requester
- req_tag  in  N_REQ x 3  ROB tag (lc3b_rob_addr) per requester
- req_ready  out  N_REQ  one-hot grant; transfer when req_valid[i] & req_ready[i] at posedge
- rob_head  in  3  ROB entry currently at commit head
- flush  in  1  mispredict/flush; kills pending broadcast and blocks grants
- cdb_out  out  20  CDB struct {valid, data, tag}, registered
- grant_idx  out  3  index of last granted requester, registered

## Operation
- Grant selection is combinational from the current inputs.
  - If flush=1: req_ready=0.
  - Else, if any i has req_valid[i] && req_tag[i]==rob_head, grant the lowest such i (head bypass).
  - Else, grant the first valid i searching from rr_ptr upward, modulo N_REQ.
  - If no requester is valid: req_ready=0.
- req_ready is one-hot or zero, never multi-hot.
- On each posedge with a grant g:
  - cdb_out ← {1, req_data[g], req_tag[g]}
  - grant_idx ← g
  - rr_ptr ← (g+1) mod N_REQ; both head-bypass and round-robin grants advance rr_ptr.
- On a posedge with no grant: cdb_out.valid ← 0; data, tag and grant_idx hold.
- If flush=1: cdb_out.valid ← 0 at the next edge; rr_ptr holds.
- The CDB has no backpressure. cdb_out.valid is high for exactly one cycle per grant.
- Requester rules:
  - Hold valid, data and tag stable until granted.
  - May drop valid only when granted, or when flush=1.
- Widths:
  - rr_ptr is $clog2(N_REQ) bits.
  - Wrap uses an explicit compare to N_REQ-1 (N_REQ need not be a power of 2).
  - grant_idx is zero-extended to 3 bits.

## Timing
- Reset (async assert, sync deassert by the system): cdb_out=0 (valid=0, data=16'h0, tag=3'h0), grant_idx=0, rr_ptr=0. req_ready follows inputs (0 while no valid).
- Latency: request accepted in cycle t; broadcast is visible in cycle t+1.
- Throughput: one result per cycle, sustained.
- A requester granted in t may present a new result in t+1. It competes with rr_ptr already advanced past it.
- Worst-case wait without head bypass: N_REQ-1 cycles.
- Simultaneous flush and valid requests: flush wins, no transfer occurs, rr_ptr is unchanged.
- Reset mid-broadcast: cdb_out.valid drops immediately, asynchronously.
- Multiple requesters matching rob_head (only possible with a stale tag): lowest index wins, deterministically.

## Structure
- lc3b_types provides:
  - the existing CDB struct and lc3b_rob_addr (used as-is);
  - new constant CDB_N_REQ = 4;
  - new typedef cdb_req_t {valid, data, tag}, allowing requesters to be bundled as an array.
- Sub-module cdb_rr_pick: combinational rotate-priority picker. Inputs are request vector and rr_ptr; outputs are one-hot grant and index.
- Head-bypass compare and muxing live in cdb_arbiter.

## Test plan
- Reset:
  - Stimulus: rst_n=0 mid-run with cdb_out.valid=1.
  - Required: cdb_out=20'h0 immediately, grant_idx=0. After release with req_valid=4'b0010: first grant goes to requester 1.
- Round-robin fairness:
  - Stimulus: req_valid=4'b1111 held, tags 0..3, rob_head=7.
  - Required: grants in order 0,1,2,3,0; cdb_out.tag matches one cycle later; cdb_out.valid high each cycle.
- Head bypass:
  - Stimulus: rr_ptr=0, req_valid=4'b1101, req_tag[2]=3'd5, rob_head=5.
  - Required: req_ready=4'b0100; cdb_out={1, req_data[2], 5} next cycle; rr_ptr becomes 3.
- Flush:
  - Stimulus: req_valid=4'b0011 with flush=1 for one cycle.
  - Required: req_ready=0, cdb_out.valid=0 next cycle, rr_ptr unchanged. After flush drops: grant goes to requester rr_ptr.
- Idle and wrap:
  - Stimulus: only requester 3 valid, then only requester 0.
  - Required: grant 3, rr_ptr wraps to 0, grant 0. Idle cycles give cdb_out.valid=0 with data held.
- Non-power-of-2 (N_REQ=3):
  - Stimulus: all requesters valid.
  - Required: grants 0,1,2,0; rr_ptr never reaches 3.
